// File: rtl/seg_message_driver_pkg.sv
// rtl/seg_message_driver_pkg.sv - shared constants and helpers for the scrolling seven-segment message driver
package seg_message_driver_pkg;

    localparam int BUF_DEPTH = 16;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;

    typedef struct packed {
        logic       hit;
        logic [1:0] offset;
    } digit_sel_t;

    // Leftmost digit (AN_DIG0) shows the nibble at the scroll pointer.
    function automatic digit_sel_t decode_anode(input logic [3:0] an);
        digit_sel_t s;
        s = '{hit: 1'b0, offset: 2'd0};
        case (an)
            AN_DIG0: s = '{hit: 1'b1, offset: 2'd0};
            AN_DIG1: s = '{hit: 1'b1, offset: 2'd1};
            AN_DIG2: s = '{hit: 1'b1, offset: 2'd2};
            AN_DIG3: s = '{hit: 1'b1, offset: 2'd3};
            default: s = '{hit: 1'b0, offset: 2'd0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_message_driver_if.sv
// rtl/seg_message_driver_if.sv - received-byte stream from the UART into the message driver
interface seg_message_driver_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;

    modport master (output rx_data, output rx_valid, output rx_error);
    modport slave  (input  rx_data, input  rx_valid, input  rx_error);
endinterface

// File: rtl/seg_message_driver_hex_to_seg.sv
// rtl/seg_message_driver_hex_to_seg.sv - combinational nibble to active-low segment pattern
module hex_to_seg
    import seg_message_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_HEX_0;
            4'h1: seg_o = SEG_HEX_1;
            4'h2: seg_o = SEG_HEX_2;
            4'h3: seg_o = SEG_HEX_3;
            4'h4: seg_o = SEG_HEX_4;
            4'h5: seg_o = SEG_HEX_5;
            4'h6: seg_o = SEG_HEX_6;
            4'h7: seg_o = SEG_HEX_7;
            4'h8: seg_o = SEG_HEX_8;
            4'h9: seg_o = SEG_HEX_9;
            4'hA: seg_o = SEG_HEX_A;
            4'hB: seg_o = SEG_HEX_B;
            4'hC: seg_o = SEG_HEX_C;
            4'hD: seg_o = SEG_HEX_D;
            4'hE: seg_o = SEG_HEX_E;
            default: seg_o = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seg_message_driver.sv
// rtl/seg_message_driver.sv - buffers UART bytes as nibbles and scrolls them across a four-digit display
module seg_message_driver
    import seg_message_driver_pkg::*;
#(
    parameter int SCROLL_TICKS = 50000000
)
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [3:0]                 anodeDelay,
    seg_message_driver_if.slave        rx,
    output logic [6:0]                 seg,
    output logic                       err_led
);

    localparam int TW = (SCROLL_TICKS > 2) ? $clog2(SCROLL_TICKS) : 1;

    logic [3:0]    msg_q [BUF_DEPTH];
    logic [3:0]    msg_d [BUF_DEPTH];
    logic [3:0]    wr_ptr_q, wr_ptr_d;
    logic [3:0]    scr_ptr_q, scr_ptr_d;
    logic [4:0]    fill_q, fill_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          err_q, err_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic [3:0]    wr_ptr_inc;
    digit_sel_t    sel;
    logic [3:0]    rd_idx;
    logic [3:0]    rd_nib;
    logic [6:0]    hex_seg;

    assign tick       = (tick_q == TW'(SCROLL_TICKS - 1));
    assign wr_ptr_inc = wr_ptr_q + 4'd1;
    assign sel        = decode_anode(anodeDelay);
    assign rd_idx     = scr_ptr_q + {2'b00, sel.offset};
    assign rd_nib     = msg_q[rd_idx];

    hex_to_seg u_hex_to_seg (
        .nibble_i (rd_nib),
        .seg_o    (hex_seg)
    );

    always_comb begin
        msg_d     = msg_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        err_d     = err_q;
        scr_ptr_d = scr_ptr_q;
        seg_d     = seg_q;
        tick_d    = tick ? '0 : tick_q + 1'b1;

        // An error pulse wins over a coincident valid: the byte is dropped.
        if (rx.rx_error) begin
            err_d = 1'b1;
        end else if (rx.rx_valid) begin
            msg_d[wr_ptr_q]   = rx.rx_data[7:4];
            msg_d[wr_ptr_inc] = rx.rx_data[3:0];
            wr_ptr_d          = wr_ptr_q + 4'd2;
            fill_d            = (fill_q >= 5'd14) ? 5'd16 : fill_q + 5'd2;
            err_d             = 1'b0;
        end

        // Scroll decision deliberately looks at the pre-write fill level.
        if (tick) begin
            scr_ptr_d = (fill_q > 5'd4) ? scr_ptr_q + 4'd1 : 4'd0;
        end

        if (sel.hit) begin
            if (err_q) begin
                seg_d = SEG_DASH;
            end else if ((fill_q != 5'd16) && ({1'b0, rd_idx} >= fill_q)) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = hex_seg;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                msg_q[i] <= 4'h0;
            end
            wr_ptr_q  <= 4'd0;
            scr_ptr_q <= 4'd0;
            fill_q    <= 5'd0;
            tick_q    <= '0;
            err_q     <= 1'b0;
            seg_q     <= SEG_BLANK;
        end else begin
            msg_q     <= msg_d;
            wr_ptr_q  <= wr_ptr_d;
            scr_ptr_q <= scr_ptr_d;
            fill_q    <= fill_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            seg_q     <= seg_d;
        end
    end

    assign seg     = seg_q;
    assign err_led = err_q;

endmodule

// File: tb/tb_seg_message_driver.sv
// tb/tb_seg_message_driver.sv - self-checking bench for seg_message_driver
module tb_seg_message_driver;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic       clock;
    logic       reset;
    logic [3:0] anodeDelay;
    logic [6:0] seg;
    logic       err_led;

    seg_message_driver_if rx_if ();

    seg_message_driver #(.SCROLL_TICKS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .anodeDelay (anodeDelay),
        .rx         (rx_if.slave),
        .seg        (seg),
        .err_led    (err_led)
    );

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] d;
        logic [3:0] an;
        logic [6:0] es;
        logic       ee;
    } vec_t;

    typedef struct {
        logic [6:0] es;
        logic       ee;
        string      nm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    function automatic logic [6:0] hex_exp(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string nm, input logic [6:0] gs, input logic [6:0] es,
                         input logic ge, input logic ee);
        checks++;
        if (gs !== es || ge !== ee) begin
            errors++;
            $display("FAIL %s: got seg=%b err_led=%b, required seg=%b err_led=%b", nm, gs, ge, es, ee);
        end
    endtask

    task automatic step(input logic v, input logic e, input logic [7:0] d, input logic [3:0] an,
                        input bit chk, input logic [6:0] es, input logic ee, input string nm);
        exp_t x;
        @(negedge clock);
        rx_if.rx_valid = v;
        rx_if.rx_error = e;
        rx_if.rx_data  = d;
        anodeDelay     = an;
        if (chk) sb.push_back('{es: es, ee: ee, nm: nm});
        @(posedge clock);
        edge_n++;
        #1;
        if (chk) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: scoreboard empty, got 0 entries required 1", nm);
            end else begin
                x = sb.pop_front();
                check(x.nm, seg, x.es, err_led, x.ee);
            end
        end
    endtask

    task automatic idle_to(input int n);
        while (edge_n < n) step(1'b0, 1'b0, 8'h00, 4'hF, 1'b0, BLANK, 1'b0, "idle");
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, 1'b0, d, 4'hF, 1'b0, BLANK, 1'b0, "write");
    endtask

    task automatic do_reset(input string nm);
        rx_if.rx_valid = 1'b0;
        rx_if.rx_error = 1'b0;
        rx_if.rx_data  = 8'h00;
        anodeDelay     = 4'hF;
        reset          = 1'b0;
        #1;
        check(nm, seg, BLANK, err_led, 1'b0);
        repeat (2) @(posedge clock);
        #2;
        reset  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h3A, 4'b1111, BLANK,      1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 4'b0111, 7'b0110000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 4'b1011, 7'b0001000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 4'b1101, BLANK,      1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 4'b1110, BLANK,      1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 4'b0111, 7'b0110000, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 4'b1111, 7'b0110000, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 4'b0101, 7'b0110000, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 4'b1111, 7'b0110000, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 4'b0111, DASH,       1'b1};
        tbl[10] = '{1'b1, 1'b1, 8'hFF, 4'b1011, DASH,       1'b1};
        tbl[11] = '{1'b1, 1'b0, 8'h07, 4'b1101, DASH,       1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 4'b1101, 7'b1000000, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 4'b1110, 7'b1111000, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 4'b1011, 7'b0001000, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 4'b0111, 7'b0110000, 1'b0};

        reset          = 1'b1;
        anodeDelay     = 4'hF;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_error = 1'b0;
        rx_if.rx_data  = 8'h00;
        #1;
        do_reset("reset_state");

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].an, 1'b1, tbl[i].es, tbl[i].ee,
                 $sformatf("table_row%0d", i));
        end

        // Scroll walk with fill=6, tick every 4 edges starting at edge 4.
        do_reset("reset_scroll");
        wr(8'h12);
        wr(8'h34);
        step(1'b0, 1'b0, 8'h00, 4'b0111, 1'b1, hex_exp(4'h1), 1'b0, "scroll_first_digit");
        step(1'b1, 1'b0, 8'h56, 4'b0111, 1'b1, hex_exp(4'h1), 1'b0, "write_on_tick_fill4");
        step(1'b0, 1'b0, 8'h00, 4'b0111, 1'b1, hex_exp(4'h1), 1'b0, "no_scroll_fill4");
        for (int m = 0; m < 16; m++) begin
            int idx;
            idx = (1 + m) % 16;
            idle_to(8 + 4 * m);
            step(1'b0, 1'b0, 8'h00, 4'b0111, 1'b1,
                 (idx < 6) ? hex_exp(4'(idx + 1)) : BLANK, 1'b0,
                 $sformatf("scroll_ptr%0d", idx));
        end
        idle_to(71);
        wr(8'h78);
        step(1'b0, 1'b0, 8'h00, 4'b0111, 1'b1, hex_exp(4'h2), 1'b0, "write_and_scroll_fill6");
        idle_to(84);
        step(1'b0, 1'b0, 8'h00, 4'b1101, 1'b1, hex_exp(4'h7), 1'b0, "tick_write_landed_hi");
        step(1'b0, 1'b0, 8'h00, 4'b1110, 1'b1, hex_exp(4'h8), 1'b0, "tick_write_landed_lo");
        step(1'b0, 1'b1, 8'h00, 4'b1111, 1'b1, hex_exp(4'h8), 1'b1, "error_before_reset");

        // Asynchronous reset mid-stream, then everything blank.
        do_reset("async_reset_mid_stream");
        step(1'b0, 1'b0, 8'h00, 4'b0111, 1'b1, BLANK, 1'b0, "post_reset_dig0");
        step(1'b0, 1'b0, 8'h00, 4'b1011, 1'b1, BLANK, 1'b0, "post_reset_dig1");
        step(1'b0, 1'b0, 8'h00, 4'b1101, 1'b1, BLANK, 1'b0, "post_reset_dig2");
        step(1'b0, 1'b0, 8'h00, 4'b1110, 1'b1, BLANK, 1'b0, "post_reset_dig3");

        // Nine bytes: fill saturates, write pointer wraps to 2.
        do_reset("reset_saturate");
        wr(8'h01); wr(8'h23); wr(8'h45); wr(8'h67); wr(8'h89);
        wr(8'hAB); wr(8'hCD); wr(8'hEF); wr(8'h9C);
        idle_to(64);
        step(1'b0, 1'b0, 8'h00, 4'b0111, 1'b1, hex_exp(4'h9), 1'b0, "wrap_buf0");
        step(1'b0, 1'b0, 8'h00, 4'b1011, 1'b1, hex_exp(4'hC), 1'b0, "wrap_buf1");
        step(1'b0, 1'b0, 8'h00, 4'b1101, 1'b1, hex_exp(4'h2), 1'b0, "wrap_buf2");
        step(1'b0, 1'b0, 8'h00, 4'b1110, 1'b1, hex_exp(4'h3), 1'b0, "wrap_buf3");
        wr(8'hD5);
        step(1'b0, 1'b0, 8'h00, 4'b1101, 1'b1, hex_exp(4'h5), 1'b0, "wr_ptr2_lo");
        step(1'b0, 1'b0, 8'h00, 4'b1011, 1'b1, hex_exp(4'hD), 1'b0, "wr_ptr2_hi");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_message_driver.md
SEG_MESSAGE_DRIVER -- requirements
Module: seg_message_driver

Interface
REQ-001 Parameter SCROLL_TICKS, default 50000000, clock cycles between scroll steps (minimum 2).
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 anodeDelay  input  4  early digit strobe from the anode scan counter; active-low one-hot (0111, 1011, 1101, 1110), 1111 = no strobe.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_valid  input  1  one-cycle pulse; rx_data is valid.
REQ-007 rx_error  input  1  one-cycle pulse; framing/parity error on the current byte.
REQ-008 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 err_led  output  1  high while the error flag is set, registered.

Function
REQ-010 Message buffer: 16 entries x 4-bit nibbles; write pointer wr_ptr (4 bit); fill count fill (0..16, saturating at 16).
REQ-011 On rx_valid=1 with rx_error=0: buf[wr_ptr] <= rx_data[7:4], buf[wr_ptr+1 mod 16] <= rx_data[3:0], wr_ptr <= wr_ptr+2 mod 16, fill <= min(fill+2,16), error flag cleared; all in the same cycle.
REQ-012 On rx_error=1: error flag set, byte discarded (buffer, wr_ptr, fill unchanged), regardless of rx_valid.
REQ-013 Tick counter counts 0..SCROLL_TICKS-1 and wraps; tick asserted for one cycle at SCROLL_TICKS-1.
REQ-014 Scroll pointer scr_ptr (4 bit): on tick with fill > 4, scr_ptr <= scr_ptr+1 mod 16; with fill <= 4, scr_ptr held at 0.
REQ-015 Write and tick in the same cycle: both take effect; the scroll decision uses fill before the write.
REQ-016 Digit select: anodeDelay 0111 -> nibble buf[scr_ptr], 1011 -> buf[scr_ptr+1], 1101 -> buf[scr_ptr+2], 1110 -> buf[scr_ptr+3], indices mod 16.
REQ-017 On a clock edge with a valid anodeDelay code, seg <= decoded pattern; latency exactly one cycle; the buffer contents sampled are those held before the edge.
REQ-018 anodeDelay = 1111 or any non-one-hot code: seg holds its value.
REQ-019 Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 Digit selected with index >= fill (when fill < 16): blank pattern 1111111 loaded.
REQ-021 Error flag set: every loaded digit = dash 0111111; err_led = 1.
REQ-022 err_led updates in the same cycle as the error flag.

Reset
REQ-023 reset=0 forces immediately: seg = 1111111, err_led = 0, error flag = 0, wr_ptr = 0, scr_ptr = 0, fill = 0, tick counter = 0, all buffer entries = 0.
REQ-024 Reset asserted mid-scroll or mid-write aborts the operation; after release the block behaves as after power-up, with no residual buffer content.
REQ-025 The first write can occur on the first rising edge after reset deasserts.

Structure
REQ-026 The shared package holds the 16 hex segment constants, BLANK and DASH patterns, the four anodeDelay code constants, and the buffer depth (16).
REQ-027 Sub-module hex_to_seg (combinational, 4-bit in, 7-bit out) implements REQ-019.
REQ-028 All other logic is in seg_message_driver; no latches; single clock domain.

Verification
REQ-029 Reset, then rx_valid with rx_data=0x3A, then anodeDelay=0111 -> seg=0110000 next cycle; anodeDelay=1011 -> seg=0001000; anodeDelay=1101 -> seg=1111111 (blank).
REQ-030 SCROLL_TICKS=4; write 0x12,0x34,0x56; cycle anodeDelay after each tick -> leftmost digit steps 1,2,3,4,5,6,1 (fill=6; wraps through blank indices 6..15 as blank) and scr_ptr wraps 15->0.
REQ-031 Write 9 bytes (18 nibbles) -> fill saturates at 16, wr_ptr=2, buf[0]/buf[1] hold byte 9 nibbles.
REQ-032 rx_error pulse -> err_led=1 next cycle, all strobed digits=0111111; rx_valid+rx_error same cycle -> byte discarded; next clean rx_valid 0x07 -> err_led=0, digits show 0,7.
REQ-033 rx_valid coincident with tick at fill=4 -> write lands, scr_ptr stays 0; at fill=6 -> both apply.
REQ-034 Assert reset mid-stream with seg=0000000 -> seg=1111111 and err_led=0 without a clock edge; after release, fill=0 and all digits blank.
